// File: rtl/procb_buf.sv
// Per-thread circular queues of process_bytes records, read through a show-ahead
// lookup port whose speculative lookups are committed or discarded by the consumer.
`ifndef N_THREADS
`define N_THREADS 8
`endif
`ifndef MSB
`define MSB(x) ($clog2((x) + 1) - 1)
`endif
`ifndef MEM_ADDR_MSB
`define MEM_ADDR_MSB 15
`endif
`ifndef PROCB_CNT_MSB
`define PROCB_CNT_MSB 6
`endif
`ifndef PROCB_D_WIDTH
`define PROCB_D_WIDTH (`MEM_ADDR_MSB + `PROCB_CNT_MSB + 3)
`endif

module procb_buf #(
  parameter int N_THREADS     = `N_THREADS,
  parameter int N_THREADS_MSB = `MSB(N_THREADS - 1),
  parameter int DEPTH         = 4,
  parameter int DEPTH_MSB     = `MSB(DEPTH - 1)
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [N_THREADS_MSB:0]    wr_thread_num,
  input  logic                      wr_en,
  input  logic [`PROCB_D_WIDTH-1:0] din,
  output logic                      wr_full,
  input  logic [N_THREADS_MSB:0]    procb_rd_thread_num,
  input  logic                      procb_lookup_en,
  input  logic                      procb_rd_en,
  input  logic                      procb_rd_rst,
  output logic                      procb_lookup_empty,
  output logic [`PROCB_D_WIDTH-1:0] procb_dout,
  output logic                      err
);

  localparam int PW = DEPTH_MSB + 2;  // slot index plus wrap bit
  localparam int DW = `PROCB_D_WIDTH;

  logic [DW-1:0]          mem [N_THREADS*DEPTH];
  logic [PW-1:0]          wr_ptr [N_THREADS];
  logic [PW-1:0]          rd_ptr [N_THREADS];
  logic [PW-1:0]          look_ofs;
  logic [N_THREADS_MSB:0] thr_r;

  logic [PW-1:0] ofs_e;
  logic [PW-1:0] la;
  logic [PW-1:0] look_ofs_nxt;
  logic          do_wr;
  logic          do_look;
  logic          do_commit;

  // A thread switch discards every uncommitted lookup of the previous thread.
  assign ofs_e              = (procb_rd_thread_num != thr_r) ? '0 : look_ofs;
  assign la                 = rd_ptr[procb_rd_thread_num] + ofs_e;
  assign procb_dout         = mem[{procb_rd_thread_num, la[DEPTH_MSB:0]}];
  assign procb_lookup_empty = (la == wr_ptr[procb_rd_thread_num]);
  assign wr_full            = ((wr_ptr[wr_thread_num] - rd_ptr[wr_thread_num]) == PW'(DEPTH));

  assign do_wr     = wr_en & ~wr_full;
  assign do_look   = procb_lookup_en & ~procb_lookup_empty;
  assign do_commit = procb_rd_en & (ofs_e != '0);

  // NOTE: every output of an always_comb gets a default first so no latch is inferred.
  always_comb begin
    look_ofs_nxt = ofs_e;
    unique case ({do_look, do_commit})
      2'b10:   look_ofs_nxt = ofs_e + PW'(1);
      2'b01:   look_ofs_nxt = ofs_e - PW'(1);
      default: look_ofs_nxt = ofs_e;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int t = 0; t < N_THREADS; t++) begin
        wr_ptr[t] <= '0;
        rd_ptr[t] <= '0;
      end
      look_ofs <= '0;
      thr_r    <= '0;
      err      <= 1'b0;
    end else begin
      thr_r <= procb_rd_thread_num;
      err   <= err | (wr_en & wr_full)
                   | (procb_lookup_en & procb_lookup_empty)
                   | (procb_rd_en & (ofs_e == '0));
      if (procb_rd_rst) begin
        for (int t = 0; t < N_THREADS; t++) begin
          wr_ptr[t] <= '0;
          rd_ptr[t] <= '0;
        end
        look_ofs <= '0;
      end else begin
        look_ofs <= look_ofs_nxt;
        if (do_wr)
          wr_ptr[wr_thread_num] <= wr_ptr[wr_thread_num] + PW'(1);
        if (do_commit)
          rd_ptr[procb_rd_thread_num] <= rd_ptr[procb_rd_thread_num] + PW'(1);
      end
    end
  end

  // NOTE: the record RAM is deliberately not reset; pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (do_wr && !procb_rd_rst)
      mem[{wr_thread_num, wr_ptr[wr_thread_num][DEPTH_MSB:0]}] <= din;
  end

endmodule

// File: tb/tb_procb_buf.sv
// Directed self-checking bench for procb_buf: fill/drain, speculative discard,
// back-to-back pipeline, pointer wrap, same-cycle write/lookup and both resets.
module tb_procb_buf;

  localparam int TW = 3;
  localparam int DW = 24;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [TW-1:0] wr_thread_num;
  logic          wr_en;
  logic [DW-1:0] din;
  logic          wr_full;
  logic [TW-1:0] procb_rd_thread_num;
  logic          procb_lookup_en;
  logic          procb_rd_en;
  logic          procb_rd_rst;
  logic          procb_lookup_empty;
  logic [DW-1:0] procb_dout;
  logic          err;

  int vectors     = 0;
  int miscompares = 0;

  procb_buf #(.N_THREADS(8), .N_THREADS_MSB(2), .DEPTH(4), .DEPTH_MSB(1)) dut (
    .CLK                 (CLK),
    .RST_N               (RST_N),
    .wr_thread_num       (wr_thread_num),
    .wr_en               (wr_en),
    .din                 (din),
    .wr_full             (wr_full),
    .procb_rd_thread_num (procb_rd_thread_num),
    .procb_lookup_en     (procb_lookup_en),
    .procb_rd_en         (procb_rd_en),
    .procb_rd_rst        (procb_rd_rst),
    .procb_lookup_empty  (procb_lookup_empty),
    .procb_dout          (procb_dout),
    .err                 (err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge; one call spans exactly one rising edge.
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic write_rec(input logic [TW-1:0] th, input logic [DW-1:0] d);
    wr_thread_num = th;
    din           = d;
    wr_en         = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
    tick();
  endtask

  // Lookup on cycle 0, lookup+commit on cycles 1..n-1, commit-only on cycle n.
  task automatic drain(input string tag, input logic [DW-1:0] base, input int n,
                       input logic exp_empty);
    procb_lookup_en = 1'b1;
    procb_rd_en     = 1'b0;
    #1 check({tag, "_dout0"}, 32'(procb_dout), 32'(base));
    tick();
    for (int k = 1; k < n; k++) begin
      procb_lookup_en = 1'b1;
      procb_rd_en     = 1'b1;
      #1 check($sformatf("%s_dout%0d", tag, k), 32'(procb_dout), 32'(base + DW'(k)));
      tick();
    end
    procb_lookup_en = 1'b0;
    procb_rd_en     = 1'b1;
    #1 check({tag, "_empty_last"}, 32'(procb_lookup_empty), 32'(exp_empty));
    tick();
    procb_rd_en = 1'b0;
    #1 check({tag, "_empty_after"}, 32'(procb_lookup_empty), 32'(exp_empty));
  endtask

  initial begin
    RST_N               = 1'b0;
    wr_thread_num       = '0;
    wr_en               = 1'b0;
    din                 = '0;
    procb_rd_thread_num = '0;
    procb_lookup_en     = 1'b0;
    procb_rd_en         = 1'b0;
    procb_rd_rst        = 1'b0;
    #3;
    check("rst_wr_full", 32'(wr_full), 32'd0);
    check("rst_empty", 32'(procb_lookup_empty), 32'd1);
    check("rst_err", 32'(err), 32'd0);
    tick();
    RST_N = 1'b1;
    tick();

    // Fill thread 5, overflow, then drain in order.
    procb_rd_thread_num = 3'd5;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("fill_notfull%0d", i), 32'(wr_full), 32'd0);
      write_rec(3'd5, 24'hA00000 + DW'(i));
    end
    #1 check("fill_full", 32'(wr_full), 32'd1);
    check("fill_err_before", 32'(err), 32'd0);
    write_rec(3'd5, 24'hA00004);
    #1 check("fill_overflow_err", 32'(err), 32'd1);
    check("fill_still_full", 32'(wr_full), 32'd1);
    drain("fill_drain", 24'hA00000, 4, 1'b1);
    check("fill_free", 32'(wr_full), 32'd0);

    // Speculative lookup on thread 2 discarded by a thread switch.
    do_reset();
    check("discard_err_cleared", 32'(err), 32'd0);
    procb_rd_thread_num = 3'd2;
    write_rec(3'd2, 24'hB00000);
    write_rec(3'd2, 24'hB00001);
    procb_lookup_en = 1'b1;
    #1 check("discard_dout_b0", 32'(procb_dout), 32'hB00000);
    tick();
    procb_lookup_en = 1'b0;
    #1 check("discard_dout_b1", 32'(procb_dout), 32'hB00001);
    procb_rd_thread_num = 3'd3;
    #1 check("discard_thr3_empty", 32'(procb_lookup_empty), 32'd1);
    tick();
    procb_rd_thread_num = 3'd2;
    #1 check("discard_back_b0", 32'(procb_dout), 32'hB00000);
    check("discard_back_nonempty", 32'(procb_lookup_empty), 32'd0);
    tick();
    #1 check("discard_settled_b0", 32'(procb_dout), 32'hB00000);
    check("discard_no_err", 32'(err), 32'd0);

    // Back-to-back lookup/commit pipeline on thread 0.
    procb_rd_thread_num = 3'd0;
    write_rec(3'd0, 24'hC00000);
    write_rec(3'd0, 24'hC00001);
    write_rec(3'd0, 24'hC00002);
    drain("b2b", 24'hC00000, 3, 1'b1);
    check("b2b_not_full", 32'(wr_full), 32'd0);
    check("b2b_no_err", 32'(err), 32'd0);

    // Ten records through thread 7 across the pointer wrap.
    procb_rd_thread_num = 3'd7;
    for (int i = 0; i < 4; i++) write_rec(3'd7, 24'hE00000 + DW'(i));
    #1 check("wrap_full_a", 32'(wr_full), 32'd1);
    drain("wrap_d0", 24'hE00000, 2, 1'b0);
    check("wrap_half_not_full", 32'(wr_full), 32'd0);
    write_rec(3'd7, 24'hE00004);
    write_rec(3'd7, 24'hE00005);
    #1 check("wrap_full_b", 32'(wr_full), 32'd1);
    drain("wrap_d1", 24'hE00002, 4, 1'b1);
    check("wrap_diff0_not_full", 32'(wr_full), 32'd0);
    for (int i = 6; i < 10; i++) write_rec(3'd7, 24'hE00000 + DW'(i));
    #1 check("wrap_full_c", 32'(wr_full), 32'd1);
    drain("wrap_d2", 24'hE00006, 4, 1'b1);
    check("wrap_end_not_full", 32'(wr_full), 32'd0);
    check("wrap_no_err", 32'(err), 32'd0);

    // Same-cycle write and lookup on an empty thread.
    do_reset();
    procb_rd_thread_num = 3'd1;
    tick();
    wr_thread_num   = 3'd1;
    din             = 24'hD00000;
    wr_en           = 1'b1;
    procb_lookup_en = 1'b1;
    #1 check("same_pre_write_empty", 32'(procb_lookup_empty), 32'd1);
    tick();
    wr_en           = 1'b0;
    procb_lookup_en = 1'b0;
    #1 check("same_err", 32'(err), 32'd1);
    check("same_visible", 32'(procb_lookup_empty), 32'd0);
    check("same_dout_d0", 32'(procb_dout), 32'hD00000);

    // procb_rd_rst with three partially filled threads.
    write_rec(3'd0, 24'hF00000);
    write_rec(3'd0, 24'hF00001);
    write_rec(3'd3, 24'hF00030);
    write_rec(3'd6, 24'hF00060);
    write_rec(3'd6, 24'hF00061);
    write_rec(3'd6, 24'hF00062);
    procb_rd_thread_num = 3'd6;
    tick();
    #1 check("rdrst_pre_dout", 32'(procb_dout), 32'hF00060);
    procb_rd_rst    = 1'b1;
    wr_thread_num   = 3'd3;
    din             = 24'hF00031;
    wr_en           = 1'b1;
    procb_lookup_en = 1'b1;
    tick();
    procb_rd_rst    = 1'b0;
    wr_en           = 1'b0;
    procb_lookup_en = 1'b0;
    #1 check("rdrst_thr6_empty", 32'(procb_lookup_empty), 32'd1);
    check("rdrst_err_kept", 32'(err), 32'd1);
    procb_rd_thread_num = 3'd3;
    #1 check("rdrst_thr3_empty", 32'(procb_lookup_empty), 32'd1);
    procb_rd_thread_num = 3'd0;
    #1 check("rdrst_thr0_empty", 32'(procb_lookup_empty), 32'd1);

    // Asynchronous reset mid-stream, observed with no clock edge.
    procb_rd_thread_num = 3'd4;
    write_rec(3'd4, 24'h400000);
    write_rec(3'd4, 24'h400001);
    write_rec(3'd4, 24'h400002);
    write_rec(3'd4, 24'h400003);
    #1 check("arst_pre_full", 32'(wr_full), 32'd1);
    check("arst_pre_nonempty", 32'(procb_lookup_empty), 32'd0);
    #1 RST_N = 1'b0;
    #1 check("arst_err", 32'(err), 32'd0);
    check("arst_full", 32'(wr_full), 32'd0);
    check("arst_empty", 32'(procb_lookup_empty), 32'd1);
    tick();
    RST_N = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
